// File: rtl/fp_norm_pkg.sv
// Shared types and width helper for the pipelined FP normaliser.
package fp_norm_pkg;

  typedef enum logic [1:0] {CARRY, ZERO, NORMAL, DENORM} norm_class_e;

  typedef struct packed {
    logic ovf;
    logic den;
    logic zero;
  } norm_flags_t;

  function automatic int lz_w(input int sig_w);
    return $clog2(sig_w + 1);
  endfunction

endpackage

// File: rtl/fp_normalize_pipe_lzc.sv
// Combinational leading-zero counter; an all-zero input returns SIG_W.
module norm_lzc #(
  parameter int SIG_W = 27,
  parameter int LZ_W  = 5
) (
  input  logic [SIG_W-1:0] sig,
  output logic [LZ_W-1:0]  lz
);

  // Ascending scan: the highest set bit is the last to write lz.
  always_comb begin
    lz = LZ_W'(SIG_W);
    for (int unsigned i = 0; i < SIG_W; i++) begin
      if (sig[i]) lz = LZ_W'(SIG_W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_normalize_pipe.sv
// Two-stage FP significand normaliser with valid/ready back-pressure.
// Build option: FP_NORM_STICKY_EN keeps the shifted-out bit as sticky on carry.
module fp_normalize_pipe
  import fp_norm_pkg::*;
#(
  parameter int SIG_W = 27,
  parameter int EXP_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SIG_W-1:0] in_sig,
  input  logic             in_carry,
  input  logic [EXP_W-1:0] in_exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIG_W-1:0] out_sig,
  output logic [EXP_W-1:0] out_exp,
  output logic [2:0]       out_flags
);

  localparam int LZ_W = lz_w(SIG_W);
  // Common width wide enough for both lz and exponent, plus one headroom bit.
  localparam int AW   = ((LZ_W > EXP_W) ? LZ_W : EXP_W) + 1;

  logic             s1_valid, s2_valid;
  logic             s1_adv, s2_adv;
  logic [LZ_W-1:0]  in_lz;
  logic [EXP_W-1:0] in_eeff;
  norm_class_e      in_class;

  logic [SIG_W-1:0] s1_sig;
  logic [LZ_W-1:0]  s1_lz;
  logic [EXP_W-1:0] s1_eeff;
  norm_class_e      s1_class;

  logic [AW-1:0]    e_ext, lz_ext, e_inc;
  logic [SIG_W-1:0] nx_sig;
  logic [EXP_W-1:0] nx_exp;
  norm_flags_t      nx_flags, flags_q;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;
  assign out_flags = flags_q;

  norm_lzc #(.SIG_W(SIG_W), .LZ_W(LZ_W)) u_lzc (.sig(in_sig), .lz(in_lz));

  assign in_eeff = (in_exp == '0) ? EXP_W'(1) : in_exp;

  always_comb begin
    if (in_carry)                         in_class = CARRY;
    else if (in_sig == '0)                in_class = ZERO;
    else if (AW'(in_lz) < AW'(in_eeff))   in_class = NORMAL;
    else                                  in_class = DENORM;
  end

  assign e_ext  = AW'(s1_eeff);
  assign lz_ext = AW'(s1_lz);
  assign e_inc  = e_ext + AW'(1);

  always_comb begin
    nx_sig   = '0;
    nx_exp   = '0;
    nx_flags = '0;
    case (s1_class)
      CARRY: begin
        if (e_inc >= AW'({EXP_W{1'b1}})) begin
          nx_exp       = '1;
          nx_flags.ovf = 1'b1;
        end else begin
          nx_sig = {1'b1, s1_sig[SIG_W-1:1]};
`ifdef FP_NORM_STICKY_EN
          nx_sig[0] = s1_sig[1] | s1_sig[0];
`else
          nx_sig[0] = s1_sig[1];
`endif
          nx_exp = EXP_W'(e_inc);
        end
      end
      ZERO:   nx_flags.zero = 1'b1;
      NORMAL: begin
        nx_sig = s1_sig << s1_lz;
        nx_exp = EXP_W'(e_ext - lz_ext);
      end
      DENORM: begin
        nx_sig       = s1_sig << (e_ext - AW'(1));
        nx_flags.den = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_sig   <= '0;
      s1_lz    <= '0;
      s1_eeff  <= '0;
      s1_class <= ZERO;
      out_sig  <= '0;
      out_exp  <= '0;
      flags_q  <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_sig   <= in_sig;
          s1_lz    <= in_lz;
          s1_eeff  <= in_eeff;
          s1_class <= in_class;
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_sig <= nx_sig;
          out_exp <= nx_exp;
          flags_q <= nx_flags;
        end
      end
    end
  end

endmodule
